// File: rtl/dice_cgra_tid_dispatcher.sv
// dice_cgra_tid_dispatcher: walks the per-launch thread active mask one word at a
// time and issues active TIDs lowest-first into the downstream TID shift register.
// Optional macro DICE_TID_DISP_PERF_EN adds the perf_issued / perf_stall counters.
module dice_cgra_tid_dispatcher #(
  parameter int TOTAL_TID = 512,
  parameter int TID_WIDTH = $clog2(TOTAL_TID),
  parameter int MASK_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [TID_WIDTH:0]   num_tid,
  input  logic                 abort,
  input  logic                 mask_valid,
  input  logic [MASK_W-1:0]    mask_data,
  output logic                 mask_ready,
  input  logic                 stall,
  output logic [TID_WIDTH-1:0] out_tid,
  output logic                 out_valid,
  input  logic                 sr_empty,
  output logic                 sr_clr,
  output logic                 busy,
  output logic                 done
`ifdef DICE_TID_DISP_PERF_EN
  ,
  output logic [31:0]          perf_issued,
  output logic [31:0]          perf_stall
`endif
);
  // base and N carry one extra bit so base >= N is visible when N == TOTAL_TID
  localparam int BW = TID_WIDTH + 1;
  localparam int IW = (MASK_W > 1) ? $clog2(MASK_W) : 1;

  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, DRAIN, DONE} state_t;

  state_t                state, state_d;
  logic [BW-1:0]         n_q, n_d, base_q, base_d, n_clamp;
  logic [MASK_W-1:0]     word_q, word_d;
  logic                  drain_arm_q, drain_arm_d;
  logic                  vld_d, clr_d;
  logic [TID_WIDTH-1:0]  tid_d;

  // index of the lowest set bit (0 for an empty word, never used then)
  function automatic logic [IW-1:0] ctz(input logic [MASK_W-1:0] w);
    ctz = '0;
    for (int i = MASK_W - 1; i >= 0; i--)
      if (w[i]) ctz = IW'(i);
  endfunction

  // drop bits whose TID lies at or beyond the launch thread count
  function automatic logic [MASK_W-1:0] trim(input logic [MASK_W-1:0] w,
                                             input logic [BW-1:0] b,
                                             input logic [BW-1:0] n);
    trim = w;
    for (int i = 0; i < MASK_W; i++)
      if ((32'(b) + 32'(i)) >= 32'(n)) trim[i] = 1'b0;
  endfunction

  assign n_clamp    = (num_tid > BW'(TOTAL_TID)) ? BW'(TOTAL_TID) : num_tid;
  assign mask_ready = (state == FETCH);
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);

  // next-state and next-datapath decode; abort overrides everything
  always_comb begin
    state_d     = state;
    n_d         = n_q;
    base_d      = base_q;
    word_d      = word_q;
    drain_arm_d = drain_arm_q;
    vld_d       = 1'b0;
    tid_d       = out_tid;
    clr_d       = 1'b0;
    case (state)
      IDLE: if (start) begin
        n_d         = n_clamp;
        base_d      = '0;
        drain_arm_d = 1'b0;
        state_d     = (n_clamp == '0) ? DRAIN : FETCH;
      end
      FETCH: if (mask_valid) begin
        word_d  = trim(mask_data, base_q, n_q);
        state_d = ISSUE;
      end
      ISSUE: if (!stall) begin
        if (word_q != '0) begin
          vld_d  = 1'b1;
          tid_d  = TID_WIDTH'(base_q + BW'(ctz(word_q)));
          word_d = word_q & (word_q - 1'b1);
        end
        // leave once the word is exhausted (an empty word costs one bubble)
        if (word_d == '0) begin
          base_d      = base_q + BW'(MASK_W);
          drain_arm_d = 1'b0;
          state_d     = (base_d >= n_q) ? DRAIN : FETCH;
        end
      end
      // first DRAIN cycle skips sr_empty: the last issue is still in flight
      DRAIN: begin
        if (!drain_arm_q) drain_arm_d = 1'b1;
        else if (sr_empty) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      word_d  = '0;
      vld_d   = 1'b0;
      clr_d   = 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q         <= '0;
      base_q      <= '0;
      word_q      <= '0;
      drain_arm_q <= 1'b0;
      out_valid   <= 1'b0;
      out_tid     <= '0;
      sr_clr      <= 1'b0;
    end else begin
      n_q         <= n_d;
      base_q      <= base_d;
      word_q      <= word_d;
      drain_arm_q <= drain_arm_d;
      out_valid   <= vld_d;
      out_tid     <= tid_d;
      sr_clr      <= clr_d;
    end
  end

`ifdef DICE_TID_DISP_PERF_EN
  // saturating perf counters, cleared when a launch is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issued <= '0;
      perf_stall  <= '0;
    end else if (state == IDLE && start && !abort) begin
      perf_issued <= '0;
      perf_stall  <= '0;
    end else begin
      if (out_valid && !(&perf_issued)) perf_issued <= perf_issued + 32'd1;
      if (state == ISSUE && stall && (word_q != '0) && !(&perf_stall))
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: doc/dice_cgra_tid_dispatcher.md
# dice_cgra_tid_dispatcher

Thread-ID issue stage directly upstream of the CGRA TID shift register. For each kernel launch, it consumes the thread active mask as a stream of MASK_W-bit words and issues one active TID per cycle into the pipe, lowest TID first. Backpressure is honoured through `stall`. After the last issue, the block waits for the downstream shift register to report empty, then pulses `done`.

## Interface
- TOTAL_TID, 512, threads per launch (maximum)
- TID_WIDTH, $clog2(TOTAL_TID), TID width
- MASK_W, 32, active-mask word width; power of two, ≤ TOTAL_TID
- clk  in  1  clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- start  in  1  launch request; accepted only in IDLE
- num_tid  in  TID_WIDTH+1  thread count N for the launch; values > TOTAL_TID are clamped to TOTAL_TID
- abort  in  1  synchronous kill of the current launch
- mask_valid  in  1  mask word valid
- mask_data  in  MASK_W  active bits for TIDs base..base+MASK_W-1 (bit i ↔ TID base+i)
- mask_ready  out  1  mask word accepted when mask_valid && mask_ready
- stall  in  1  downstream backpressure; blocks issue
- out_tid  out  TID_WIDTH  issued TID (registered)
- out_valid  out  1  issue strobe (registered)
- sr_empty  in  1  empty flag from the downstream TID shift register
- sr_clr  out  1  one-cycle flush pulse to downstream on abort
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse

## Operation
- **States:** IDLE, FETCH, ISSUE, DRAIN, DONE.
- **IDLE:** mask_ready=0.
  - On start, latch N = min(num_tid, TOTAL_TID) and set base=0.
  - If N==0, go to DRAIN; otherwise go to FETCH.
- **FETCH:** mask_ready=1.
  - On handshake, latch word = mask_data with bit i cleared wherever base+i ≥ N.
  - Go to ISSUE.
- **ISSUE:** mask_ready=0.
  - If word≠0 and !stall: register out_valid=1 and out_tid=base+ctz(word), then clear that bit.
  - If stall: out_valid=0 and the state is frozen.
  - The state exits on the cycle the word becomes zero after an issue, or immediately if the word was already zero (one bubble cycle, no issue). On exit, base += MASK_W.
  - If the new base ≥ N, go to DRAIN; otherwise go to FETCH.
- **DRAIN:** sr_empty is ignored in the first DRAIN cycle, because the final out_valid is still in flight. From the second cycle on, sr_empty==1 moves the block to DONE.
- **DONE:** done=1 for exactly one cycle, then go to IDLE.
- **abort:** in any state, go to IDLE on the next edge.
  - Clears out_valid and word.
  - Pulses sr_clr for one cycle.
  - No done pulse.
  - Has priority over start and over every other transition.
- **Width:** base is TID_WIDTH+1 bits so that base ≥ N is detectable when N=TOTAL_TID. out_tid is the low TID_WIDTH bits.
- **start outside IDLE:** ignored.

## Timing
- **Reset values:** out_valid=0, out_tid=0, mask_ready=0, sr_clr=0, busy=0, done=0, state=IDLE.
- **start to first issue:** start at cycle 0 → FETCH in cycle 1. If the mask word handshakes in cycle 1, ISSUE in cycle 2 and out_valid high in cycle 3.
- **Throughput:** a word with k set bits costs 1 FETCH cycle + max(k,1) ISSUE cycles plus stall cycles.
- **stall:** affects ISSUE only. A stall asserted in cycle t forces out_valid=0 in cycle t+1.
- **Reset mid-launch:** asynchronous return to IDLE with all outputs at their reset values.

## Configuration
- **DICE_TID_DISP_PERF_EN defined:** adds 32-bit outputs perf_issued and perf_stall.
  - perf_issued counts out_valid cycles.
  - perf_stall counts ISSUE cycles with stall && word≠0.
  - Both clear on start acceptance and on reset, and saturate at all-ones.
- **Not defined:** ports and counters are absent. Functional behaviour is identical.

## Test plan
- **Full launch:** N=64, MASK_W=32, both words 0xFFFFFFFF, no stall → out_tid 0..63 on 64 consecutive valid cycles except one FETCH bubble between words. With sr_empty tied high, done pulses 2 cycles after the last out_valid.
- **Sparse and partial mask:** N=40, words 0x80000001 and 0xFFFFFFFF → issue 0, 31, 32..39 only. Bits for TIDs 40..63 are suppressed.
- **Stall:** stall held for 5 cycles mid-word → out_valid low for exactly 5 cycles, then issue continues with no TID lost or duplicated.
- **Zero word and N=0:** word 0x0 → one ISSUE bubble, no issue, advance to next word. N=0 → no mask handshake, done once sr_empty is high.
- **Drain wait:** sr_empty held low for 10 cycles after the last issue → done is delayed until the first cycle after sr_empty rises. busy stays high throughout.
- **Abort:** abort mid-ISSUE → out_valid=0 next cycle, sr_clr pulses once, no done, IDLE. A start on the following cycle launches normally.
